// File: rtl/sram_bus_arbiter_if.sv
// Fetch, MEM-stage and SRAM-like bus signals seen by sram_bus_arbiter.
// master = arbiter side, slave = requesters plus bus model.
interface sram_bus_arbiter_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        bus_req;
  logic        bus_wr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_addr_ok;
  logic        bus_data_ok;
  logic [31:0] bus_rdata;

  modport master (
    input  inst_req, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_wstrb, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    input  bus_addr_ok, bus_data_ok, bus_rdata
  );

  modport slave (
    output inst_req, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_wstrb, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  bus_req, bus_wr, bus_wstrb, bus_addr, bus_wdata,
    output bus_addr_ok, bus_data_ok, bus_rdata
  );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Two-requester (fetch/MEM) arbiter onto one SRAM-like bus, one transaction outstanding; grant->data_ok >= 2 cycles,
// requesters stall until *_addr_ok, bus stalls via bus_addr_ok/bus_data_ok. ARB_ROUND_ROBIN_EN selects fair arbitration.
module sram_bus_arbiter (
  input  logic                      clk,
  input  logic                      rst,
  sram_bus_arbiter_if.master        sif,
  output logic                      busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADDR = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;

  logic [1:0]  state;
  logic        owner_data;
  logic        wr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic in_idle;
  logic in_addr;
  logic in_wait;
  logic prefer_data;
  logic grant_data;
  logic grant_inst;
  logic done;

  // Everything is gated by rst so outputs stay quiet while reset is held.
  assign in_idle = rst && (state == IDLE);
  assign in_addr = rst && (state == ADDR);
  assign in_wait = rst && (state == WAIT);

`ifdef ARB_ROUND_ROBIN_EN
  logic last_data;

  assign prefer_data = !last_data;

  // Reset value means "data was granted last", so the first contested grant goes to fetch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      last_data <= 1'b1;
    end else if (grant_data || grant_inst) begin
      last_data <= grant_data;
    end
  end
`else
  assign prefer_data = 1'b1;
`endif

  assign grant_data = in_idle && sif.data_req && (!sif.inst_req || prefer_data);
  assign grant_inst = in_idle && sif.inst_req && !grant_data;
  assign done       = in_wait && sif.bus_data_ok;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      owner_data <= 1'b0;
      wr_q       <= 1'b0;
      wstrb_q    <= 4'b0000;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            owner_data <= 1'b1;
            wr_q       <= sif.data_wr;
            wstrb_q    <= sif.data_wstrb;
            addr_q     <= sif.data_addr;
            wdata_q    <= sif.data_wdata;
            state      <= ADDR;
          end else if (grant_inst) begin
            owner_data <= 1'b0;
            wr_q       <= 1'b0;
            wstrb_q    <= 4'b0000;
            addr_q     <= sif.inst_addr;
            wdata_q    <= 32'h0;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (sif.bus_addr_ok) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (sif.bus_data_ok) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sif.inst_addr_ok = grant_inst;
  assign sif.data_addr_ok = grant_data;
  assign sif.inst_data_ok = done && !owner_data;
  assign sif.data_data_ok = done && owner_data;
  assign sif.inst_rdata   = (done && !owner_data) ? sif.bus_rdata : 32'h0;
  // Write completions return zero rather than whatever the bus leaves on rdata.
  assign sif.data_rdata   = (done && owner_data && !wr_q) ? sif.bus_rdata : 32'h0;

  assign sif.bus_req   = in_addr;
  assign sif.bus_wr    = in_addr && wr_q;
  assign sif.bus_wstrb = in_addr ? wstrb_q : 4'b0000;
  assign sif.bus_addr  = in_addr ? addr_q  : 32'h0;
  assign sif.bus_wdata = in_addr ? wdata_q : 32'h0;

  assign busy = rst && (state != IDLE);

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed cycle table plus randomized traffic checked against a transaction-level model.
module tb_sram_bus_arbiter;

  typedef struct packed {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwr;
    logic [3:0]  dwstrb;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic        baok;
    logic        bdok;
    logic [31:0] brdata;
  } ins_t;

  typedef struct packed {
    logic        iaok;
    logic        idok;
    logic [31:0] irdata;
    logic        daok;
    logic        ddok;
    logic [31:0] drdata;
    logic        breq;
    logic        bwr;
    logic [3:0]  bwstrb;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        busy;
  } outs_t;

  typedef struct {
    string name;
    ins_t  i;
    outs_t o;
  } vec_t;

  typedef struct {
    bit          owner_data;
    bit          wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          acked;
  } txn_t;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;
  localparam logic [31:0] Z32 = 32'h0;
  localparam logic [3:0]  Z4  = 4'h0;

  logic clk;
  logic rst;
  logic busy;
  sram_bus_arbiter_if sif ();

  sram_bus_arbiter dut (
    .clk  (clk),
    .rst  (rst),
    .sif  (sif),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];
  txn_t pend[$];
  bit   m_last_data = 1'b1;

  function automatic ins_t vi(bit r, bit ireq, logic [31:0] iaddr, bit dreq, bit dwr,
                              logic [3:0] dwstrb, logic [31:0] daddr, logic [31:0] dwdata,
                              bit baok, bit bdok, logic [31:0] brdata);
    ins_t x;
    x = '{r, ireq, iaddr, dreq, dwr, dwstrb, daddr, dwdata, baok, bdok, brdata};
    return x;
  endfunction

  function automatic outs_t vo(bit iaok, bit idok, logic [31:0] ird, bit daok, bit ddok,
                               logic [31:0] drd, bit breq, bit bwr, logic [3:0] bws,
                               logic [31:0] ba, logic [31:0] bwd, bit bsy);
    outs_t o;
    o = '{iaok, idok, ird, daok, ddok, drd, breq, bwr, bws, ba, bwd, bsy};
    return o;
  endfunction

  task automatic add(input string n, input ins_t i, input outs_t o);
    vec_t v;
    v.name = n;
    v.i    = i;
    v.o    = o;
    vecs.push_back(v);
  endtask

  // 0 = no grant, 1 = fetch, 2 = MEM; fairness remembers who won last.
  function automatic int pick(ins_t x);
    if (x.ireq && x.dreq) return (RR && m_last_data) ? 1 : 2;
    if (x.dreq) return 2;
    if (x.ireq) return 1;
    return 0;
  endfunction

  function automatic outs_t model_outs(ins_t x);
    outs_t o;
    txn_t  t;
    int    g;
    o = '0;
    if (!x.rst) return o;
    if (pend.size() == 0) begin
      g = pick(x);
      o.iaok = (g == 1);
      o.daok = (g == 2);
    end else begin
      t = pend[0];
      o.busy = 1'b1;
      if (!t.acked) begin
        o.breq   = 1'b1;
        o.bwr    = t.wr;
        o.bwstrb = t.wstrb;
        o.baddr  = t.addr;
        o.bwdata = t.wdata;
      end else if (x.bdok) begin
        if (t.owner_data) begin
          o.ddok   = 1'b1;
          o.drdata = t.wr ? 32'h0 : x.brdata;
        end else begin
          o.idok   = 1'b1;
          o.irdata = x.brdata;
        end
      end
    end
    return o;
  endfunction

  task automatic model_step(input ins_t x);
    txn_t t;
    int   g;
    if (!x.rst) begin
      pend.delete();
      m_last_data = 1'b1;
    end else if (pend.size() == 0) begin
      g = pick(x);
      if (g != 0) begin
        t.owner_data = (g == 2);
        t.wr         = (g == 2) ? x.dwr : 1'b0;
        t.wstrb      = (g == 2) ? x.dwstrb : 4'h0;
        t.addr       = (g == 2) ? x.daddr : x.iaddr;
        t.wdata      = (g == 2) ? x.dwdata : 32'h0;
        t.acked      = 1'b0;
        pend.push_back(t);
        m_last_data = (g == 2);
      end
    end else if (!pend[0].acked) begin
      if (x.baok) pend[0].acked = 1'b1;
    end else if (x.bdok) begin
      void'(pend.pop_front());
    end
  endtask

  task automatic apply(input ins_t x, output outs_t got, output outs_t mexp);
    @(negedge clk);
    rst             = x.rst;
    sif.inst_req    = x.ireq;
    sif.inst_addr   = x.iaddr;
    sif.data_req    = x.dreq;
    sif.data_wr     = x.dwr;
    sif.data_wstrb  = x.dwstrb;
    sif.data_addr   = x.daddr;
    sif.data_wdata  = x.dwdata;
    sif.bus_addr_ok = x.baok;
    sif.bus_data_ok = x.bdok;
    sif.bus_rdata   = x.brdata;
    #2;
    got = {sif.inst_addr_ok, sif.inst_data_ok, sif.inst_rdata,
           sif.data_addr_ok, sif.data_data_ok, sif.data_rdata,
           sif.bus_req, sif.bus_wr, sif.bus_wstrb, sif.bus_addr, sif.bus_wdata, busy};
    mexp = model_outs(x);
    @(posedge clk);
    model_step(x);
  endtask

  task automatic check(input string n, input int cyc, input outs_t got, input outs_t exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", n, cyc, got, exp);
    end
  endtask

  initial begin
    outs_t z;
    outs_t got;
    outs_t mexp;
    ins_t  idle_i;
    ins_t  x;
    z      = '0;
    idle_i = vi(H, L, Z32, L, L, Z4, Z32, Z32, L, L, Z32);
    rst = 1'b0;
    sif.inst_req = 1'b0; sif.inst_addr = '0; sif.data_req = 1'b0; sif.data_wr = 1'b0;
    sif.data_wstrb = '0; sif.data_addr = '0; sif.data_wdata = '0;
    sif.bus_addr_ok = 1'b0; sif.bus_data_ok = 1'b0; sif.bus_rdata = '0;

    // reset: outputs quiet even with requests pending
    add("rst_req",  vi(L, H, 32'h1, H, L, Z4, 32'h2, Z32, L, H, 32'h9), z);
    add("rst_idle", vi(L, L, Z32, L, L, Z4, Z32, Z32, L, L, Z32), z);
    add("idle",     idle_i, z);
    // single fetch read, minimum latency
    add("i_grant", vi(H, H, 32'hBFC00000, L, L, Z4, Z32, Z32, L, L, Z32), vo(H, L, Z32, L, L, Z32, L, L, Z4, Z32, Z32, L));
    add("i_addr",  vi(H, L, Z32, L, L, Z4, Z32, Z32, H, L, Z32), vo(L, L, Z32, L, L, Z32, H, L, Z4, 32'hBFC00000, Z32, H));
    add("i_data",  vi(H, L, Z32, L, L, Z4, Z32, Z32, L, H, 32'h3C1D0001), vo(L, H, 32'h3C1D0001, L, L, Z32, L, L, Z4, Z32, Z32, H));
    add("i_idle",  idle_i, z);
    // contested back-to-back: fetch won last, so MEM first either way
    add("s1_grant", vi(H, H, 32'hBFC00010, H, L, Z4, 32'h80000020, Z32, L, L, Z32), vo(L, L, Z32, H, L, Z32, L, L, Z4, Z32, Z32, L));
    add("s1_addr",  vi(H, H, 32'hBFC00010, H, L, Z4, 32'h80000020, Z32, H, L, Z32), vo(L, L, Z32, L, L, Z32, H, L, Z4, 32'h80000020, Z32, H));
    add("s1_done",  vi(H, H, 32'hBFC00010, H, L, Z4, 32'h80000020, Z32, L, H, 32'h11112222), vo(L, L, Z32, L, H, 32'h11112222, L, L, Z4, Z32, Z32, H));
    add("s2_grant", vi(H, H, 32'hBFC00010, H, L, Z4, 32'h80000020, Z32, L, L, Z32),
        RR ? vo(H, L, Z32, L, L, Z32, L, L, Z4, Z32, Z32, L) : vo(L, L, Z32, H, L, Z32, L, L, Z4, Z32, Z32, L));
    add("s2_addr",  vi(H, L, Z32, L, L, Z4, Z32, Z32, H, L, Z32),
        vo(L, L, Z32, L, L, Z32, H, L, Z4, RR ? 32'hBFC00010 : 32'h80000020, Z32, H));
    add("s2_data",  vi(H, L, Z32, L, L, Z4, Z32, Z32, L, H, 32'h33334444),
        RR ? vo(L, H, 32'h33334444, L, L, Z32, L, L, Z4, Z32, Z32, H) : vo(L, L, Z32, L, H, 32'h33334444, L, L, Z4, Z32, Z32, H));
    add("s_idle", idle_i, z);
    // MEM write, bus_addr_ok held off 3 cycles while requester inputs change
    add("w_grant", vi(H, L, Z32, H, H, 4'b0011, 32'h80001000, 32'h0000BEEF, L, L, Z32), vo(L, L, Z32, H, L, Z32, L, L, Z4, Z32, Z32, L));
    for (int k = 0; k < 3; k++)
      add("w_hold", vi(H, L, Z32, L, H, 4'hF, 32'hDEADDEAD, 32'hCAFECAFE, L, L, Z32), vo(L, L, Z32, L, L, Z32, H, H, 4'b0011, 32'h80001000, 32'h0000BEEF, H));
    add("w_aok",   vi(H, L, Z32, L, L, Z4, Z32, Z32, H, L, Z32), vo(L, L, Z32, L, L, Z32, H, H, 4'b0011, 32'h80001000, 32'h0000BEEF, H));
    add("w_done",  vi(H, L, Z32, L, L, Z4, Z32, Z32, L, H, 32'hFFFFFFFF), vo(L, L, Z32, L, H, Z32, L, L, Z4, Z32, Z32, H));
    add("w_idle",  idle_i, z);
    // spurious bus_data_ok while waiting for address acceptance
    add("p_grant", vi(H, H, 32'h00000100, L, L, Z4, Z32, Z32, L, L, Z32), vo(H, L, Z32, L, L, Z32, L, L, Z4, Z32, Z32, L));
    for (int k = 0; k < 2; k++)
      add("p_spur", vi(H, L, Z32, L, L, Z4, Z32, Z32, L, H, 32'hAAAA5555), vo(L, L, Z32, L, L, Z32, H, L, Z4, 32'h00000100, Z32, H));
    add("p_aok",   vi(H, L, Z32, L, L, Z4, Z32, Z32, H, L, Z32), vo(L, L, Z32, L, L, Z32, H, L, Z4, 32'h00000100, Z32, H));
    add("p_data",  vi(H, L, Z32, L, L, Z4, Z32, Z32, L, H, 32'h12345678), vo(L, H, 32'h12345678, L, L, Z32, L, L, Z4, Z32, Z32, H));
    add("p_idle",  idle_i, z);
    // reset while in WAIT, then a late bus_data_ok
    add("r_grant", vi(H, L, Z32, H, L, Z4, 32'h80002000, Z32, L, L, Z32), vo(L, L, Z32, H, L, Z32, L, L, Z4, Z32, Z32, L));
    add("r_addr",  vi(H, L, Z32, L, L, Z4, Z32, Z32, H, L, Z32), vo(L, L, Z32, L, L, Z32, H, L, Z4, 32'h80002000, Z32, H));
    add("r_wait",  idle_i, vo(L, L, Z32, L, L, Z32, L, L, Z4, Z32, Z32, H));
    add("r_rst",   vi(L, L, Z32, L, L, Z4, Z32, Z32, L, L, Z32), z);
    add("r_rel",   idle_i, z);
    add("r_late",  vi(H, L, Z32, L, L, Z4, Z32, Z32, L, H, 32'h77777777), z);
    add("r_idle",  idle_i, z);
    // fairness pointer restarts at "data last" after reset
    add("f_grant", vi(H, H, 32'h00001000, H, L, Z4, 32'h00002000, Z32, L, L, Z32),
        RR ? vo(H, L, Z32, L, L, Z32, L, L, Z4, Z32, Z32, L) : vo(L, L, Z32, H, L, Z32, L, L, Z4, Z32, Z32, L));
    add("f_addr",  vi(H, L, Z32, L, L, Z4, Z32, Z32, H, L, Z32),
        vo(L, L, Z32, L, L, Z32, H, L, Z4, RR ? 32'h00001000 : 32'h00002000, Z32, H));
    add("f_data",  vi(H, L, Z32, L, L, Z4, Z32, Z32, L, H, 32'h00000005),
        RR ? vo(L, H, 32'h5, L, L, Z32, L, L, Z4, Z32, Z32, H) : vo(L, L, Z32, L, H, 32'h5, L, L, Z4, Z32, Z32, H));
    add("f_idle",  idle_i, z);

    foreach (vecs[k]) begin
      apply(vecs[k].i, got, mexp);
      check(vecs[k].name, k, got, vecs[k].o);
    end

    for (int c = 0; c < 3000; c++) begin
      x.rst    = ($urandom_range(0, 63) != 0);
      x.ireq   = $urandom_range(0, 1) == 1;
      x.iaddr  = $urandom;
      x.dreq   = $urandom_range(0, 1) == 1;
      x.dwr    = $urandom_range(0, 1) == 1;
      x.dwstrb = 4'($urandom_range(0, 15));
      x.daddr  = $urandom;
      x.dwdata = $urandom;
      x.baok   = $urandom_range(0, 1) == 1;
      x.bdok   = $urandom_range(0, 4) < 2;
      x.brdata = $urandom;
      apply(x, got, mexp);
      check("rand", c, got, mexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
